// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix keypad scanner with frame-level debounce.
// Drives one active-low row at a time, samples the synchronised active-low
// columns at the end of each row slot, and presents an accepted frame as a
// 16-bit one-hot key code (bit = 4*row + col), plus a press strobe.
// Optional build macro KEYPAD_MULTI_REJECT_EN: accepted patterns with two or
// more keys encode to zero (chord/ghost rejection). When undefined, the
// lowest-index pressed key wins.
module keypad_scan_4x4 #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        RSTn,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_press
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_SCANS);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_SCANS - 1);

  // Scan states; the state value is also the driven row index.
  localparam logic [1:0] StRow0 = 2'd0;
  localparam logic [1:0] StRow1 = 2'd1;
  localparam logic [1:0] StRow2 = 2'd2;
  localparam logic [1:0] StRow3 = 2'd3;

  logic [3:0]      col_meta_q, col_sync_q;
  logic [1:0]      state_q, state_d;
  logic [DivW-1:0] div_cnt_q;
  logic [15:0]     frame_q;
  logic            frame_done_q;
  logic [15:0]     prev_q;
  logic [CntW-1:0] stable_cnt_q;
  logic [15:0]     onehot_q;
  logic            key_press_q;
  logic [15:0]     enc;
  logic            sample;

  assign sample = (div_cnt_q == DivLast);

  // Two-flop synchroniser for the asynchronous column inputs
  always_ff @(posedge clk) begin
    if (RSTn) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // Next row state: plain ring with no idle state
  always_comb begin
    state_d = StRow0;
    unique case (state_q)
      StRow0:  state_d = StRow1;
      StRow1:  state_d = StRow2;
      StRow2:  state_d = StRow3;
      StRow3:  state_d = StRow0;
      default: state_d = StRow0;
    endcase
  end

  // Row slot divider; advance the row after the sample cycle
  always_ff @(posedge clk) begin
    if (RSTn) begin
      state_q   <= StRow0;
      div_cnt_q <= '0;
    end else if (sample) begin
      state_q   <= state_d;
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DivW'(1);
    end
  end

  // Active-low row drive: only the current row is pulled low
  always_comb begin
    row          = 4'b1111;
    row[state_q] = 1'b0;
  end

  // Capture inverted columns into the frame; flag the completed frame
  always_ff @(posedge clk) begin
    if (RSTn) begin
      frame_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= sample && (state_q == StRow3);
      if (sample) begin
        frame_q[{state_q, 2'b00} +: 4] <= ~col_sync_q;
      end
    end
  end

`ifdef KEYPAD_MULTI_REJECT_EN
  logic multi;
  // Chords encode to no key at all
  always_comb begin
    multi = |(frame_q & (frame_q - 16'd1));
    enc   = multi ? 16'h0000 : frame_q;
  end
`else
  // Isolate the lowest set bit (zero stays zero, one-hot passes through)
  always_comb begin
    enc = frame_q & (~frame_q + 16'd1);
  end
`endif

  // Frame-level debounce: accept once after DEBOUNCE_SCANS repeats of a frame
  always_ff @(posedge clk) begin
    if (RSTn) begin
      prev_q       <= '0;
      stable_cnt_q <= '0;
      onehot_q     <= '0;
      key_press_q  <= 1'b0;
    end else begin
      key_press_q <= 1'b0;
      if (frame_done_q) begin
        if (frame_q != prev_q) begin
          prev_q       <= frame_q;
          stable_cnt_q <= '0;
        end else if (stable_cnt_q < CntMax) begin
          stable_cnt_q <= stable_cnt_q + CntW'(1);
          if (stable_cnt_q == CntLast) begin
            onehot_q    <= enc;
            key_press_q <= (enc != 16'h0000) && (enc != onehot_q);
          end
        end
      end
    end
  end

  assign onehot    = onehot_q;
  assign key_valid = |onehot_q;
  assign key_press = key_press_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: a keypad model drives the columns from the row
// drive; key patterns change once per frame from a schedule (directed cases
// then random holds). A frame-level run-length model predicts outputs.
module tb_keypad_scan_4x4;

  localparam int unsigned ScanDiv = 8;
  localparam int unsigned DebScans = 3;
  localparam int FrameLen = 4 * ScanDiv;

  logic        clk;
  logic        RSTn;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_press;

  keypad_scan_4x4 #(
    .SCAN_DIV      (ScanDiv),
    .DEBOUNCE_SCANS(DebScans)
  ) dut (
    .clk      (clk),
    .RSTn     (RSTn),
    .row      (row),
    .col      (col),
    .onehot   (onehot),
    .key_valid(key_valid),
    .key_press(key_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a held key shorts its column low when its row is driven
  logic [15:0] keys;
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[4*r+c]) col[c] = 1'b0;
        end
      end
    end
  end

  int n_vec;
  int n_err;
  int t;
  logic [15:0] sched[$];
  logic [15:0] frame_keys;
  logic [15:0] last_p;
  int          run_len;
  logic [15:0] exp_onehot;
  logic        exp_press;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [15:0] p);
    int n;
    logic [15:0] lo;
    n  = 0;
    lo = '0;
    for (int i = 15; i >= 0; i--) begin
      if (p[i]) begin
        n++;
        lo = 16'h1 << i;
      end
    end
`ifdef KEYPAD_MULTI_REJECT_EN
    return (n >= 2) ? 16'h0000 : p;
`else
    return lo;
`endif
  endfunction

  // A pattern is accepted when it has been seen DebScans+1 frames in a row
  // (the reset state counts as one empty frame); accepted once per run.
  task automatic model_frame(input logic [15:0] p);
    logic [15:0] e;
    if (p == last_p) run_len++;
    else begin
      last_p  = p;
      run_len = 1;
    end
    if (run_len == DebScans + 1) begin
      e          = encode(p);
      exp_press  = (e != 16'h0000) && (e != exp_onehot);
      exp_onehot = e;
    end
  endtask

  task automatic step();
    logic [3:0] er;
    exp_press = 1'b0;
    if ((t % FrameLen == 1) && (t > FrameLen)) model_frame(frame_keys);
    er = 4'b1111;
    er[(t / ScanDiv) % 4] = 1'b0;
    check_val("row", {12'h0, row}, {12'h0, er});
    check_val("onehot", onehot, exp_onehot);
    check_val("key_valid", {15'h0, key_valid}, {15'h0, |exp_onehot});
    check_val("key_press", {15'h0, key_press}, {15'h0, exp_press});
    if (t % FrameLen == 1) begin
      if (sched.size() > 0) keys = sched.pop_front();
      frame_keys = keys;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset(input int n);
    RSTn = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check_val("rst_row", {12'h0, row}, 16'h000e);
      check_val("rst_onehot", onehot, 16'h0000);
      check_val("rst_valid", {15'h0, key_valid}, 16'h0000);
      check_val("rst_press", {15'h0, key_press}, 16'h0000);
    end
    RSTn       = 1'b0;
    t          = 0;
    last_p     = '0;
    run_len    = 1;
    exp_onehot = '0;
    exp_press  = 1'b0;
  endtask

  task automatic push_hold(input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) sched.push_back(p);
  endtask

  function automatic logic [15:0] rand_pat();
    int unsigned sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return 16'h0000;
      1:       return 16'h1 << $urandom_range(0, 15);
      2:       return (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    n_vec      = 0;
    n_err      = 0;
    t          = 0;
    keys       = '0;
    frame_keys = '0;
    RSTn       = 1'b1;
    do_reset(3);

    push_hold(16'h0100, 6);
    for (int i = 0; i < 10; i++) sched.push_back((i % 2 == 0) ? 16'h0000 : 16'h0100);
    push_hold(16'h0100, 6);
    push_hold(16'h0000, 6);
    push_hold(16'h0080, 6);
    push_hold(16'h2008, 6);
    push_hold(16'h0008, 5);
    push_hold(16'h0000, 2);
    repeat (30) push_hold(rand_pat(), int'($urandom_range(1, 6)));
    push_hold(16'h0100, 6);
    while (sched.size() > 0) step();

    // Reset while row 2 is driven, then re-acquire the still-held key
    while (t % FrameLen != 2 * ScanDiv + 2) step();
    check_val("pre_rst_onehot", onehot, 16'h0100);
    do_reset(1);
    repeat (6 * FrameLen) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
